// File: rtl/pr_wb_bridge_n.sv
// Processor device-bus to Wishbone classic bridge for NSLV slaves, with a
// wait-state timeout that returns an error and a registered, maskable IRQ vector.
module pr_wb_bridge_n #(
   parameter int          NSLV     = 4,
   parameter int          AW       = 5,
   parameter int          DW       = 8,
   parameter logic [15:0] DEV_BASE = 16'h7F00,
   parameter int          TIMEOUT  = 15
) (
   input  logic                 PClk,
   input  logic                 Reset,
   input  logic [31:2]          PrA,
   input  logic [31:0]          PrWData,
   input  logic                 PrReq,
   input  logic                 PrRW,
   output logic [31:0]          PrRData,
   output logic                 PrReady,
   output logic                 PrErr,
   output logic [AW-1:0]        wb_adr,
   output logic [DW-1:0]        wb_dat_o,
   output logic                 wb_we,
   output logic [NSLV-1:0]      wb_stb,
   input  logic [NSLV-1:0]      wb_ack,
   input  logic [NSLV*DW-1:0]   wb_dat_i,
   input  logic [NSLV-1:0]      slv_irq,
   input  logic [NSLV-1:0]      irq_mask,
   output logic [NSLV-1:0]      HWInt,
   output logic [1:0]           dbg_state
);

   localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam logic [IW:0] NSLV_W = (IW+1)'(NSLV);
   localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STROBE = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic [1:0] S_ERR    = 2'd3;

   // Handshake: PrReq is held by the CPU until it sees PrReady; PrReady is a
   // single-cycle pulse and PrErr is meaningful only while PrReady is high.

   logic [1:0]      state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [AW-1:0]   adr_q, adr_d;
   logic [DW-1:0]   dat_q, dat_d;
   logic            we_q, we_d;
   logic [NSLV-1:0] stb_q, stb_d;
   logic            ready_q, ready_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [NSLV-1:0] hwint_q, hwint_d;

   logic [IW-1:0]   req_idx;
   logic            req_hit;
   logic            ack_sel;
   logic [DW-1:0]   rd_slice;
   logic            unused_bits;

   assign req_idx  = PrA[AW+2+IW-1:AW+2];
   assign req_hit  = (PrA[31:16] == DEV_BASE) && ({1'b0, req_idx} < NSLV_W);
   assign ack_sel  = wb_ack[idx_q];
   assign rd_slice = wb_dat_i[32'(idx_q)*DW +: DW];
   assign unused_bits = ^{PrA, PrWData};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      stb_d   = '0;
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      hwint_d = slv_irq & irq_mask;
      case (state_q)
         S_IDLE: begin
            if (PrReq) begin
               if (req_hit) begin
                  state_d = S_STROBE;
                  idx_d   = req_idx;
                  adr_d   = PrA[AW+1:2];
                  dat_d   = PrWData[DW-1:0];
                  we_d    = PrRW;
                  cnt_d   = 8'd0;
                  stb_d   = NSLV'(1) << req_idx;
               end else begin
                  state_d = S_ERR;
                  ready_d = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end
            end
         end
         S_STROBE: begin
            // An ack arriving on the expiry edge still completes normally.
            if (ack_sel) begin
               state_d = S_DONE;
               ready_d = 1'b1;
               rdata_d = we_q ? 32'd0 : 32'(rd_slice);
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_ERR;
               ready_d = 1'b1;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
               stb_d = stb_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge PClk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= 8'd0;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         stb_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         hwint_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         stb_q   <= stb_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         hwint_q <= hwint_d;
      end
   end

   assign PrRData   = rdata_q;
   assign PrReady   = ready_q;
   assign PrErr     = err_q;
   assign wb_adr    = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_we     = we_q;
   assign wb_stb    = stb_q;
   assign HWInt     = hwint_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pr_wb_bridge_n.sv
// Randomized bench for pr_wb_bridge_n: a transaction-level model predicts the
// outputs of every cycle; directed cases pin the model with literal values.
module tb_pr_wb_bridge_n;

   localparam int          NSLV     = 4;
   localparam int          AW       = 5;
   localparam int          DW       = 8;
   localparam logic [15:0] DEV_BASE = 16'h7F00;
   localparam int          TIMEOUT  = 15;
   localparam int          IW       = 2;

   logic                PClk;
   logic                Reset;
   logic [31:2]         PrA;
   logic [31:0]         PrWData;
   logic                PrReq;
   logic                PrRW;
   logic [31:0]         PrRData;
   logic                PrReady;
   logic                PrErr;
   logic [AW-1:0]       wb_adr;
   logic [DW-1:0]       wb_dat_o;
   logic                wb_we;
   logic [NSLV-1:0]     wb_stb;
   logic [NSLV-1:0]     wb_ack;
   logic [NSLV*DW-1:0]  wb_dat_i;
   logic [NSLV-1:0]     slv_irq;
   logic [NSLV-1:0]     irq_mask;
   logic [NSLV-1:0]     HWInt;
   logic [1:0]          dbg_state;

   pr_wb_bridge_n #(
      .NSLV(NSLV), .AW(AW), .DW(DW), .DEV_BASE(DEV_BASE), .TIMEOUT(TIMEOUT)
   ) dut (
      .PClk(PClk), .Reset(Reset), .PrA(PrA), .PrWData(PrWData), .PrReq(PrReq),
      .PrRW(PrRW), .PrRData(PrRData), .PrReady(PrReady), .PrErr(PrErr),
      .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_we(wb_we), .wb_stb(wb_stb),
      .wb_ack(wb_ack), .wb_dat_i(wb_dat_i), .slv_irq(slv_irq),
      .irq_mask(irq_mask), .HWInt(HWInt), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial PClk = 1'b0;
   always #5 PClk = ~PClk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [NSLV-1:0] stb;
      logic [AW-1:0]   adr;
      logic [DW-1:0]   dat;
      logic            we;
      logic            ready;
      logic            err;
      logic [31:0]     rdata;
      logic [NSLV-1:0] hwint;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_rdata = 32'd0;
   logic        force_a5 = 1'b0;
   logic        spur     = 1'b0;

   int              stb_cnt   = 0;
   int              obs_cnt   = 0;
   logic            obs_err   = 1'b0;
   logic [31:0]     obs_rdata = 32'd0;
   logic [NSLV-1:0] last_stb  = '0;
   logic [AW-1:0]   last_adr  = '0;
   logic [DW-1:0]   last_dat  = '0;
   logic            last_we   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge PClk) begin
      exp_t ce;
      #1;
      if (exp_q.size() != 0) begin
         ce = exp_q.pop_front();
         chk("stb",   32'(wb_stb),  32'(ce.stb));
         chk("ready", 32'(PrReady), 32'(ce.ready));
         chk("err",   32'(PrErr),   32'(ce.err));
         chk("rdata", PrRData,      ce.rdata);
         chk("hwint", 32'(HWInt),   32'(ce.hwint));
         if (ce.stb != '0) begin
            chk("adr",   32'(wb_adr),   32'(ce.adr));
            chk("dat_o", 32'(wb_dat_o), 32'(ce.dat));
            chk("we",    32'(wb_we),    32'(ce.we));
         end
         if (wb_stb != '0) begin
            stb_cnt++;
            last_stb = wb_stb;
            last_adr = wb_adr;
            last_dat = wb_dat_o;
            last_we  = wb_we;
         end
         if (PrReady) begin
            obs_cnt   = stb_cnt;
            stb_cnt   = 0;
            obs_err   = PrErr;
            obs_rdata = PrRData;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic rand_misc();
      slv_irq  = NSLV'($urandom);
      irq_mask = NSLV'($urandom);
      for (int i = 0; i < NSLV; i++) wb_dat_i[i*DW +: DW] = DW'($urandom);
      if (force_a5) wb_dat_i[0 +: DW] = DW'(8'hA5);
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e = '0;
      e.rdata = m_rdata;
      e.hwint = slv_irq & irq_mask;
      return e;
   endfunction

   // ack_delay: index of the strobe cycle (0 = first) in which the selected
   // slave acks; values >= TIMEOUT mean it never acks.
   task automatic run_txn(input logic [31:0] full, input logic [31:0] wd, input logic rw,
                          input int ack_delay, input int drop_at);
      exp_t            e;
      int              idx;
      logic [AW-1:0]   adr;
      logic [NSLV-1:0] oh;
      logic            hit;
      logic [DW-1:0]   s;
      idx = int'((full >> (AW + 2)) & ((32'd1 << IW) - 1));
      adr = AW'((full >> 2) & ((32'd1 << AW) - 1));
      hit = (full[31:16] == DEV_BASE) && (idx < NSLV);
      oh  = hit ? NSLV'(1 << idx) : '0;

      @(negedge PClk);
      rand_misc();
      PrReq = 1'b1; PrA = full[31:2]; PrWData = wd; PrRW = rw;
      wb_ack = NSLV'($urandom);
      e = idle_exp();
      if (!hit) begin
         e.ready = 1'b1; e.err = 1'b1; m_rdata = 32'd0; e.rdata = 32'd0;
         exp_q.push_back(e);
      end else begin
         e.stb = oh; e.adr = adr; e.dat = wd[DW-1:0]; e.we = rw;
         exp_q.push_back(e);
         for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge PClk);
            rand_misc();
            wb_ack = NSLV'($urandom);
            if (spur) wb_ack = wb_ack | NSLV'(1 << (NSLV - 1));
            wb_ack = wb_ack & ~oh;
            if (k == ack_delay) wb_ack = wb_ack | oh;
            if (k >= drop_at) PrReq = 1'b0;
            e = idle_exp();
            if (k == ack_delay) begin
               s = wb_dat_i[idx*DW +: DW];
               m_rdata = rw ? 32'd0 : 32'(s);
               e.ready = 1'b1; e.rdata = m_rdata;
               exp_q.push_back(e);
               break;
            end else if (k == TIMEOUT - 1) begin
               m_rdata = 32'd0;
               e.ready = 1'b1; e.err = 1'b1; e.rdata = 32'd0;
               exp_q.push_back(e);
            end else begin
               e.stb = oh; e.adr = adr; e.dat = wd[DW-1:0]; e.we = rw;
               exp_q.push_back(e);
            end
         end
      end
      @(negedge PClk);
      rand_misc();
      PrReq = 1'b0;
      wb_ack = NSLV'($urandom);
      exp_q.push_back(idle_exp());
   endtask

   function automatic logic [31:0] dev_addr(input int idx, input int adr);
      return {DEV_BASE, 16'h0} | 32'(idx << (AW + 2)) | 32'(adr << 2);
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] full;
      Reset = 1'b0; PrA = '0; PrWData = '0; PrReq = 1'b0; PrRW = 1'b0;
      wb_ack = '0; wb_dat_i = '0; slv_irq = '1; irq_mask = '1;
      #12;
      chk("reset_stb",   32'(wb_stb),  32'd0);
      chk("reset_ready", 32'(PrReady), 32'd0);
      chk("reset_err",   32'(PrErr),   32'd0);
      chk("reset_rdata", PrRData,      32'd0);
      chk("reset_hwint", 32'(HWInt),   32'd0);
      @(negedge PClk);
      Reset = 1'b1;

      // write to slave 1 reg 3, ack in third strobe cycle, spurious ack[3]
      spur = 1'b1;
      run_txn(dev_addr(1, 3), 32'h0000_005A, 1'b1, 2, 1000);
      spur = 1'b0;
      chk("t1_stb_cycles", 32'(obs_cnt), 32'd3);
      chk("t1_stb",  32'(last_stb), 32'h2);
      chk("t1_adr",  32'(last_adr), 32'd3);
      chk("t1_dat",  32'(last_dat), 32'h5A);
      chk("t1_we",   32'(last_we),  32'd1);
      chk("t1_err",  32'(obs_err),  32'd0);

      // zero-wait read of slave 0 reg 0
      force_a5 = 1'b1;
      run_txn(dev_addr(0, 0), 32'hFFFF_FFFF, 1'b0, 0, 1000);
      force_a5 = 1'b0;
      chk("t2_stb_cycles", 32'(obs_cnt), 32'd1);
      chk("t2_rdata", obs_rdata, 32'h0000_00A5);
      chk("t2_err",   32'(obs_err), 32'd0);

      // slave 2 never acks
      run_txn(dev_addr(2, 7), 32'h0, 1'b0, 1000, 1000);
      chk("t3_stb_cycles", 32'(obs_cnt), 32'd15);
      chk("t3_err",   32'(obs_err), 32'd1);
      chk("t3_rdata", obs_rdata, 32'd0);

      // ack on the expiry edge wins
      run_txn(dev_addr(3, 1), 32'h0, 1'b0, TIMEOUT - 1, 1000);
      chk("t_edge_stb_cycles", 32'(obs_cnt), 32'd15);
      chk("t_edge_err", 32'(obs_err), 32'd0);

      // decode miss on upper address
      run_txn(32'h1234_0000 | dev_addr(1, 2) & 32'h0000_FFFF, 32'h0, 1'b0, 0, 1000);
      chk("t4_stb_cycles", 32'(obs_cnt), 32'd0);
      chk("t4_err",   32'(obs_err), 32'd1);

      // PrReq dropped mid-strobe still completes
      run_txn(dev_addr(1, 9), 32'h33, 1'b1, 3, 1);
      chk("t_drop_stb_cycles", 32'(obs_cnt), 32'd4);
      chk("t_drop_err", 32'(obs_err), 32'd0);

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         full = $urandom;
         if ($urandom_range(0, 7) != 0) full[31:16] = DEV_BASE;
         run_txn(full, $urandom, 1'($urandom), $urandom_range(0, TIMEOUT + 1),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 1000);
      end

      // asynchronous reset in the middle of a strobe
      @(negedge PClk);
      PrReq = 1'b1; PrA = dev_addr(1, 4) >> 2; PrRW = 1'b0; wb_ack = '0;
      slv_irq = '1; irq_mask = '1;
      @(posedge PClk); #1;
      chk("t6_stb_before", 32'(wb_stb), 32'h2);
      @(posedge PClk); #3;
      Reset = 1'b0;
      #1;
      chk("t6_stb",   32'(wb_stb),  32'd0);
      chk("t6_ready", 32'(PrReady), 32'd0);
      chk("t6_hwint", 32'(HWInt),   32'd0);
      chk("t6_rdata", PrRData,      32'd0);
      @(negedge PClk);
      PrReq = 1'b0; slv_irq = 4'b1010; irq_mask = 4'b0011;
      @(negedge PClk);
      Reset = 1'b1;
      m_rdata = 32'd0;
      @(posedge PClk); #1;
      chk("t6_hwint_after", 32'(HWInt), 32'h2);
      chk("t6_ready_after", 32'(PrReady), 32'd0);

      // bridge serviceable after reset
      run_txn(dev_addr(2, 5), 32'h0, 1'b0, 1, 1000);
      chk("t6_next_err", 32'(obs_err), 32'd0);
      chk("t6_next_stb_cycles", 32'(obs_cnt), 32'd2);

      @(negedge PClk);
      @(negedge PClk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
